// File: rtl/alu_div16_seq.sv
// ---------------------------------------------------------------------------
// alu_div16_seq -- sequential unsigned restoring divider (16-bit)
//
// Drives an external registered full subtractor (one cycle latency) and
// consumes its registered result. Every quotient bit costs two cycles:
// PRESENT (subtractor captures operands) and CAPTURE (commit one bit).
// The result is latched during DONE and stays stable until the next result.
//
// Optional feature macro: ALU_DIV_ZERO_CHECK_EN
//   defined     : a zero divisor skips the iteration (IDLE -> DONE), sets dz
//   not defined : a zero divisor runs the full sequence, dz is tied to 0
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   request a division, sampled only in IDLE
//   dividend   in   [WIDTH] captured when start is accepted
//   divisor    in   [WIDTH] captured when start is accepted
//   busy       out  high in PRESENT / CAPTURE
//   done       out  one-cycle pulse; quotient/remainder/dz valid next cycle
//   quotient   out  [WIDTH] result quotient
//   remainder  out  [WIDTH] result remainder
//   dz         out  divide-by-zero flag
//   sub_a      out  [WIDTH] subtractor minuend
//   sub_b      out  [WIDTH] subtractor subtrahend
//   sub_bin    out  subtractor borrow-in (always 0)
//   sub_diff   in   [WIDTH] registered difference
//   sub_bout   in   registered borrow-out
//   dbg_state  out  [2] current FSM state (0 IDLE,1 PRESENT,2 CAPTURE,3 DONE)
//
// Handshake: start is a level request; it is accepted on the rising edge
// at which the FSM is in IDLE and start=1. No back-pressure exists; done is a
// single-cycle strobe and the result registers update on the following edge.
// ---------------------------------------------------------------------------
module alu_div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_bin,
    input  logic [WIDTH-1:0] sub_diff,
    input  logic             sub_bout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;       // partial remainder
    logic [WIDTH-1:0] q_q, q_d;       // shifting dividend / quotient
    logic [WIDTH-1:0] d_q, d_d;       // divisor
    logic [4:0]       cnt_q, cnt_d;   // bits still to commit
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sub_ok;

    // Subtractor drive comes straight from registers, so it is stable for the
    // whole PRESENT/CAPTURE pair.
    assign sub_a     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign sub_b     = d_q;
    assign sub_bin   = 1'b0;

    assign busy      = (state_q == S_PRESENT) || (state_q == S_CAPTURE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbg_state = state_q;

    // The shifted remainder is 17 bits wide; its top bit is r_q[MSB]. When it
    // is set the subtract always succeeds and the low bits of sub_diff are
    // exact, so the borrow-out is irrelevant.
    assign sub_ok = r_q[WIDTH-1] || !sub_bout;

`ifdef ALU_DIV_ZERO_CHECK_EN
    logic dz_q, dz_d;
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
`ifdef ALU_DIV_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = 5'(WIDTH);
                    state_d = S_PRESENT;
`ifdef ALU_DIV_ZERO_CHECK_EN
                    dz_d = 1'b0;
                    // Zero divisor: load the final answer directly so DONE
                    // publishes it through the normal path.
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = dividend;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_PRESENT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (sub_ok) begin
                    r_d = sub_diff;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q == 5'd1) ? S_DONE : S_PRESENT;
            end
            S_DONE: begin
                quot_d  = q_q;
                rem_d   = r_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

`ifdef ALU_DIV_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dz_q <= 1'b0;
        else      dz_q <= dz_d;
    end
`endif

endmodule

// File: tb/tb_alu_div16_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_div16_seq -- bench for alu_div16_seq
//
// Includes a behavioural model of the registered 16-bit subtractor. Expected
// results come from plain '/' and '%' arithmetic and are queued when a start
// is accepted; a monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_alu_div16_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dz;
    logic [15:0] sub_a;
    logic [15:0] sub_b;
    logic        sub_bin;
    logic [15:0] sub_diff;
    logic        sub_bout;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;
    int cyc;

    // scoreboard: {dz, quotient, remainder}, accept cycle, expected latency
    logic [32:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];

`ifdef ALU_DIV_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    alu_div16_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_bin   (sub_bin),
        .sub_diff  (sub_diff),
        .sub_bout  (sub_bout),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // registered subtractor: 17-bit subtract, borrow-out is bit 16
    initial begin
        sub_diff = '0;
        sub_bout = 1'b0;
    end
    always @(posedge clk) begin
        {sub_bout, sub_diff} <= {1'b0, sub_a} - {1'b0, sub_b} - {16'd0, sub_bin};
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input int acc);
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          lat;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
        z   = ZCHK && (b == 16'd0);
        lat = z ? 0 : 32;
        exp_q.push_back({z, q, r});
        acc_q.push_back(acc);
        lat_q.push_back(lat);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_bound", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // issue one division, queue its expectation, then scramble the operands
    task automatic do_div(input logic [15:0] a, input logic [15:0] b);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        push_exp(a, b, cyc);
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
    endtask

    // ---------------- monitor ----------------
    logic [32:0] mon_e;
    int          mon_acc;
    int          mon_lat;

    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                mon_lat = lat_q.pop_front();
                check("done_latency", 32'(cyc - mon_acc), 32'(mon_lat));
                @(negedge clk);
                check("quotient", {16'd0, quotient}, {16'd0, mon_e[31:16]});
                check("remainder", {16'd0, remainder}, {16'd0, mon_e[15:0]});
                check("dz", {31'd0, dz}, {31'd0, mon_e[32]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        int nb;
        logic [15:0] ra;
        logic [15:0] rb;

        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        check("rst_sub_a", {16'd0, sub_a}, 32'd0);
        check("rst_sub_b", {16'd0, sub_b}, 32'd0);
        check("rst_sub_bin", {31'd0, sub_bin}, 32'd0);
        rst = 1'b1;

        // 100 / 7 with busy-width measurement
        do_div(16'd100, 16'd7);
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) nb++;
            else break;
        end
        check("busy_cycles", 32'(nb), 32'd32);

        // edge operands and the 17-bit MSB path
        do_div(16'd65535, 16'd1);
        do_div(16'd5, 16'd10);
        do_div(16'd0, 16'd3);
        do_div(16'd65535, 16'd65534);
        do_div(16'd65535, 16'd32769);
        do_div(16'd1234, 16'd0);
        do_div(16'd4321, 16'd9);   // dz clears again on a nonzero divisor

        // start re-pulsed mid-operation with different operands is ignored
        do_div(16'd1000, 16'd7);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd2;
        repeat (3) @(negedge clk);
        start    = 1'b0;

        // back-to-back with start held: second accept 34 cycles after first
        wait_idle();
        start    = 1'b1;
        dividend = 16'd40000;
        divisor  = 16'd123;
        @(posedge clk);
        #1;
        c0 = cyc;
        push_exp(16'd40000, 16'd123, c0);
        push_exp(16'd40000, 16'd123, c0 + 34);
        repeat (34) @(posedge clk);
        #1;
        start = 1'b0;

        // reset in the middle of 50000 / 3
        do_div(16'd50000, 16'd3);
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        check("abort_dz", {31'd0, dz}, 32'd0);
        check("abort_sub_a", {16'd0, sub_a}, 32'd0);
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        void'(lat_q.pop_back());
        repeat (3) @(negedge clk);
        check("abort_done_held", {31'd0, done}, 32'd0);
        rst = 1'b1;
        do_div(16'd50000, 16'd3);

        // randomized operands
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom_range(0, 15));
                1:       rb = 16'($urandom_range(0, 65535));
                2:       rb = ra >> $urandom_range(0, 15);
                default: rb = 16'($urandom_range(32768, 65535));
            endcase
            do_div(ra, rb);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // absolute time guard
    initial begin
        #2000000;
        $display("FAIL time_limit: got no completion expected finish before %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
